// File: rtl/edf_dispatcher.sv
// edf_dispatcher: earliest-deadline-first arbiter that feeds one Serializer transaction at a time
module edf_dispatcher #(
    parameter int NUM_QUEUES     = 4,
    parameter int PACKET_WIDTH   = 678,
    parameter int DEADLINE_WIDTH = 16,
    parameter int MISS_CNT_WIDTH = 16
) (
    input  logic                                   M_AXI_ACLK,
    input  logic                                   M_AXI_ARESET,
    input  logic [NUM_QUEUES-1:0]                  q_valid,
    input  logic [NUM_QUEUES*PACKET_WIDTH-1:0]     q_packet,
    input  logic [NUM_QUEUES*DEADLINE_WIDTH-1:0]   q_deadline,
    output logic [NUM_QUEUES-1:0]                  q_pop,
    output logic                                   INIT_AXI_TXN,
    output logic [PACKET_WIDTH-1:0]                packet_out,
    input  logic                                   packetConsumed,
    output logic [DEADLINE_WIDTH-1:0]              now,
    output logic                                   busy,
    output logic [$clog2(NUM_QUEUES)-1:0]          grant_id,
    output logic                                   miss_pulse,
    output logic [NUM_QUEUES*MISS_CNT_WIDTH-1:0]   miss_count
);
    localparam int IW = $clog2(NUM_QUEUES);
    localparam int DW = DEADLINE_WIDTH;
    localparam int MW = MISS_CNT_WIDTH;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_LOW, WAIT_HIGH} state_t;

    state_t          state, state_nxt;
    logic [DW-1:0]   slack [NUM_QUEUES];
    logic [IW-1:0]   win_idx;
    logic [DW-1:0]   win_slack;
    logic            found;
    logic            fire;

    genvar i;
    for (i = 0; i < NUM_QUEUES; i++) begin : g_slack
        assign slack[i] = q_deadline[i*DW +: DW] - now;
    end

    // Pick the valid queue with the smallest signed slack; strict compare keeps the lowest index on ties
    always_comb begin
        win_idx   = '0;
        win_slack = '0;
        found     = 1'b0;
        for (int k = 0; k < NUM_QUEUES; k++) begin
            if (q_valid[k] && (!found || $signed(slack[k]) < $signed(win_slack))) begin
                found     = 1'b1;
                win_idx   = IW'(k);
                win_slack = slack[k];
            end
        end
    end

    assign fire = (state == IDLE) && found && packetConsumed && !M_AXI_ARESET;

    // Next state plus pop/miss strobes issued in the dispatch cycle
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     state_nxt = fire ? ISSUE : IDLE;
            ISSUE:    state_nxt = WAIT_LOW;
            WAIT_LOW: state_nxt = packetConsumed ? WAIT_LOW : WAIT_HIGH;
            default:  state_nxt = packetConsumed ? IDLE : WAIT_HIGH;
        endcase
        q_pop        = fire ? (NUM_QUEUES'(1) << win_idx) : '0;
        miss_pulse   = fire && win_slack[DW-1];
        INIT_AXI_TXN = state == ISSUE;
        busy         = state != IDLE;
    end

    // State, time base, latched packet and saturating per-queue miss counters
    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            state      <= IDLE;
            now        <= '0;
            packet_out <= '0;
            grant_id   <= '0;
            miss_count <= '0;
        end else begin
            state <= state_nxt;
            now   <= now + DW'(1);
            if (fire) begin
                packet_out <= q_packet[win_idx*PACKET_WIDTH +: PACKET_WIDTH];
                grant_id   <= win_idx;
                if (win_slack[DW-1] && miss_count[win_idx*MW +: MW] != '1)
                    miss_count[win_idx*MW +: MW] <= miss_count[win_idx*MW +: MW] + MW'(1);
            end
        end
    end
endmodule

// File: tb/tb_edf_dispatcher.sv
// tb_edf_dispatcher: directed scoreboard bench for the EDF dispatcher and a narrow-counter instance
module tb_edf_dispatcher;
    localparam int NQ = 4;
    localparam int PW = 678;
    localparam int DW = 16;
    localparam int MW = 16;

    typedef struct {
        int             id;
        logic [PW-1:0]  pkt;
        logic           miss;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NQ-1:0]     q_valid = '0;
    logic [NQ*PW-1:0]  q_packet = '0;
    logic [NQ*DW-1:0]  q_deadline = '0;
    logic [NQ-1:0]     q_pop;
    logic              INIT_AXI_TXN;
    logic [PW-1:0]     packet_out;
    logic              packetConsumed;
    logic [DW-1:0]     now;
    logic              busy;
    logic [1:0]        grant_id;
    logic              miss_pulse;
    logic [NQ*MW-1:0]  miss_count;

    logic [1:0]        q_valid_s = '0;
    logic [15:0]       q_packet_s = '0;
    logic [15:0]       q_deadline_s = '0;
    logic [1:0]        q_pop_s;
    logic              init_s;
    logic [7:0]        packet_out_s;
    logic              pc_s;
    logic [7:0]        now_s;
    logic              busy_s;
    logic [0:0]        grant_s;
    logic              miss_pulse_s;
    logic [3:0]        miss_count_s;
    logic              init_d = 1'b0;

    logic [DW-1:0]     tnow = '0;
    int                ser_len = 6;
    int                ser_cnt = 0;
    logic              ser_block = 1'b0;
    logic [MW-1:0]     mc_model [NQ];
    exp_t              exp_q [$];
    int                checks = 0;
    int                errors = 0;

    edf_dispatcher #(.NUM_QUEUES(NQ), .PACKET_WIDTH(PW), .DEADLINE_WIDTH(DW), .MISS_CNT_WIDTH(MW)) dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESET(rst), .q_valid(q_valid), .q_packet(q_packet),
        .q_deadline(q_deadline), .q_pop(q_pop), .INIT_AXI_TXN(INIT_AXI_TXN), .packet_out(packet_out),
        .packetConsumed(packetConsumed), .now(now), .busy(busy), .grant_id(grant_id),
        .miss_pulse(miss_pulse), .miss_count(miss_count)
    );

    edf_dispatcher #(.NUM_QUEUES(2), .PACKET_WIDTH(8), .DEADLINE_WIDTH(8), .MISS_CNT_WIDTH(2)) dut_s (
        .M_AXI_ACLK(clk), .M_AXI_ARESET(rst), .q_valid(q_valid_s), .q_packet(q_packet_s),
        .q_deadline(q_deadline_s), .q_pop(q_pop_s), .INIT_AXI_TXN(init_s), .packet_out(packet_out_s),
        .packetConsumed(pc_s), .now(now_s), .busy(busy_s), .grant_id(grant_s),
        .miss_pulse(miss_pulse_s), .miss_count(miss_count_s)
    );

    always #5 clk = ~clk;

    // Reference time base
    always @(posedge clk) tnow <= rst ? '0 : tnow + 16'd1;

    // Serializer model: packetConsumed low for ser_len cycles after each start pulse
    always @(posedge clk) ser_cnt <= rst ? 0 : INIT_AXI_TXN ? ser_len : (ser_cnt != 0 ? ser_cnt - 1 : 0);
    assign packetConsumed = (ser_cnt == 0) && !ser_block;

    // Minimal Serializer for the narrow instance: one low cycle after each start pulse
    always @(posedge clk) init_d <= init_s;
    assign pc_s = ~init_d;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [PW-1:0] rand_pkt();
        logic [PW-1:0] p;
        for (int k = 0; k < PW; k++) p[k] = 1'($urandom_range(0, 1));
        return p;
    endfunction

    task automatic present(input int q, input logic [PW-1:0] p, input logic [DW-1:0] dl);
        q_packet[q*PW +: PW]   = p;
        q_deadline[q*DW +: DW] = dl;
        q_valid[q]             = 1'b1;
    endtask

    task automatic push(input int id, input logic [PW-1:0] p, input logic m);
        exp_t e;
        e.id   = id;
        e.pkt  = p;
        e.miss = m;
        exp_q.push_back(e);
    endtask

    // Wait for the next dispatch, pop the expected grant and follow the transaction back to IDLE
    task automatic serve(input bit mut, input logic [PW-1:0] mut_pkt);
        exp_t e;
        int n;
        int hi;
        #1;
        n = 0;
        while (q_pop === '0 && n < 60) begin
            tick();
            #1;
            n++;
        end
        check("pop_timeout", n < 60, 1'b1);
        e = exp_q.pop_front();
        check("pop_onehot", q_pop, 1 << e.id);
        check("miss_pulse", miss_pulse, e.miss);
        check("init_early", INIT_AXI_TXN, 1'b0);
        tick();
        q_valid[e.id] = 1'b0;
        #1;
        check("init_pulse", INIT_AXI_TXN, 1'b1);
        check("grant_id", grant_id, e.id);
        check("packet_out", packet_out, e.pkt);
        check("pop_once", q_pop, 0);
        check("miss_once", miss_pulse, 1'b0);
        check("miss_count", miss_count[e.id*MW +: MW], mc_model[e.id]);
        tick();
        #1;
        check("init_once", INIT_AXI_TXN, 1'b0);
        n = 0;
        hi = 0;
        while (busy === 1'b1 && n < 60) begin
            check("hold_packet", packet_out, e.pkt);
            check("hold_pop", q_pop, 0);
            if (packetConsumed === 1'b1) hi++;
            if (mut && n == 1) present(0, mut_pkt, tnow + 16'd50);
            tick();
            #1;
            n++;
        end
        check("busy_timeout", n < 60, 1'b1);
        check("busy_fall", hi, 1);
        check("now", now, tnow);
    endtask

    initial begin
        logic [PW-1:0] p [NQ];
        logic [PW-1:0] pb;
        int sat;
        int pops;
        for (int k = 0; k < NQ; k++) mc_model[k] = '0;
        repeat (3) tick();
        rst = 1'b0;
        #1;
        check("rst_now", now, tnow);
        check("rst_busy", busy, 1'b0);
        check("rst_pop", q_pop, 0);
        check("rst_init", INIT_AXI_TXN, 1'b0);
        check("rst_miss", miss_pulse, 1'b0);
        check("rst_packet", packet_out, 0);
        check("rst_grant", grant_id, 0);
        check("rst_miss_count", miss_count, 0);

        // single request on q1
        tick();
        p[1] = rand_pkt();
        present(1, p[1], tnow + 16'd100);
        push(1, p[1], 1'b0);
        serve(1'b0, '0);

        // EDF order with slack 40/10/10/25
        ser_len = 1;
        tick();
        for (int k = 0; k < NQ; k++) p[k] = rand_pkt();
        present(0, p[0], tnow + 16'd40);
        present(1, p[1], tnow + 16'd10);
        present(2, p[2], tnow + 16'd10);
        present(3, p[3], tnow + 16'd25);
        push(1, p[1], 1'b0);
        push(2, p[2], 1'b0);
        push(3, p[3], 1'b0);
        push(0, p[0], 1'b0);
        repeat (4) serve(1'b0, '0);

        // late packet on q2 is counted and still dispatched
        tick();
        p[2] = rand_pkt();
        present(2, p[2], tnow - 16'd3);
        push(2, p[2], 1'b1);
        mc_model[2] = mc_model[2] + 16'd1;
        serve(1'b0, '0);

        // source change during the burst has no effect until IDLE
        ser_len = 6;
        tick();
        p[0] = rand_pkt();
        pb = rand_pkt();
        present(0, p[0], tnow + 16'd60);
        push(0, p[0], 1'b0);
        push(0, pb, 1'b0);
        serve(1'b1, pb);
        serve(1'b0, '0);

        // Serializer busy in IDLE blocks dispatch
        ser_block = 1'b1;
        tick();
        p[3] = rand_pkt();
        present(3, p[3], tnow + 16'd80);
        for (int k = 0; k < 3; k++) begin
            #1;
            check("blocked_pop", q_pop, 0);
            check("blocked_init", INIT_AXI_TXN, 1'b0);
            check("blocked_busy", busy, 1'b0);
            tick();
        end
        ser_block = 1'b0;
        push(3, p[3], 1'b0);
        serve(1'b0, '0);

        // reset in WAIT_LOW aborts, the pending request is dispatched again afterwards
        tick();
        p[1] = rand_pkt();
        present(1, p[1], tnow + 16'd100);
        #1;
        check("mid_pop", q_pop, 4'b0010);
        tick();
        #1;
        check("mid_init", INIT_AXI_TXN, 1'b1);
        tick();
        #1;
        check("mid_wait_low", busy, 1'b1);
        rst = 1'b1;
        tick();
        #1;
        for (int k = 0; k < NQ; k++) mc_model[k] = '0;
        check("mrst_busy", busy, 1'b0);
        check("mrst_pop", q_pop, 0);
        check("mrst_init", INIT_AXI_TXN, 1'b0);
        check("mrst_miss", miss_pulse, 1'b0);
        check("mrst_packet", packet_out, 0);
        check("mrst_grant", grant_id, 0);
        check("mrst_miss_count", miss_count, 0);
        check("mrst_now", now, 0);
        rst = 1'b0;
        q_deadline[1*DW +: DW] = tnow + 16'd100;
        push(1, p[1], 1'b0);
        serve(1'b0, '0);

        // wrap-around on the 8-bit instance: now=F0, q0 dl 05 (slack +21), q1 dl F8 (slack +8)
        for (int k = 0; k < 300 && tnow[7:0] != 8'hF0; k++) tick();
        check("wrap_now", now_s, 8'hF0);
        q_packet_s   = {8'hB1, 8'hA0};
        q_deadline_s = {8'hF8, 8'h05};
        q_valid_s    = 2'b11;
        #1;
        check("wrap_pop_q1", q_pop_s, 2'b10);
        check("wrap_miss_q1", miss_pulse_s, 1'b0);
        tick();
        q_valid_s = 2'b01;
        #1;
        check("wrap_init", init_s, 1'b1);
        check("wrap_pkt_q1", packet_out_s, 8'hB1);
        check("wrap_grant_q1", grant_s, 1'b1);
        for (int k = 0; k < 20 && q_pop_s !== 2'b01; k++) begin
            tick();
            #1;
        end
        check("wrap_pop_q0", q_pop_s, 2'b01);
        check("wrap_miss_q0", miss_pulse_s, 1'b0);
        tick();
        q_valid_s = 2'b00;
        #1;
        check("wrap_pkt_q0", packet_out_s, 8'hA0);
        check("wrap_grant_q0", grant_s, 1'b0);
        check("wrap_no_miss", miss_count_s, 4'h0);

        // 2-bit counter saturates at all-ones under repeated misses
        sat = 0;
        pops = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            q_valid_s = 2'b01;
            q_deadline_s[7:0] = tnow[7:0] - 8'd3;
            #1;
            if (q_pop_s === 2'b01) begin
                pops++;
                check("sat_miss_pulse", miss_pulse_s, 1'b1);
                sat = (sat == 3) ? 3 : sat + 1;
            end
        end
        tick();
        q_valid_s = 2'b00;
        #1;
        check("sat_pops", pops >= 4, 1'b1);
        check("sat_count_model", miss_count_s[1:0], sat);
        check("sat_count", miss_count_s[1:0], 2'b11);
        check("sat_other", miss_count_s[3:2], 2'b00);
        repeat (6) tick();
        #1;
        check("sat_idle", busy_s, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
